// File: rtl/conn_setup_pkg.sv
// Shared types for the session-setup responder: opcodes, setconn types,
// the UDP header bundle and the FSM state encoding.
package conn_setup_pkg;

  localparam logic [7:0] OPC_OPEN   = 8'd7;
  localparam logic [7:0] OPC_CLOSE  = 8'd8;
  localparam logic [5:0] SETC_OPEN  = 6'd1;
  localparam logic [5:0] SETC_CLOSE = 6'd2;

  typedef struct packed {
    logic [15:0] length;
    logic [15:0] dst_port;
    logic [15:0] src_port;
    logic [31:0] dst_ip;
    logic [31:0] src_ip;
  } udp_hdr_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RHDR,
    S_RB0,
    S_RB1,
    S_DRAIN,
    S_SETC,
    S_THDR,
    S_TB0,
    S_TB1
  } state_t;

endpackage

// File: rtl/conn_setup_responder.sv
// Lego open/close-session endpoint: parses RX packets, programs the conn table,
// replies to the requester. Define CONN_CLOSE_EN to honour close requests.
module conn_setup_responder
  import conn_setup_pkg::*;
#(
  parameter int SLOT_W = 10
) (
  input  logic          ap_clk,
  input  logic          ap_rst_n,
  input  logic [111:0]  usr_rx_hdr_V_TDATA,
  input  logic          usr_rx_hdr_V_TVALID,
  output logic          usr_rx_hdr_V_TREADY,
  input  logic [63:0]   usr_rx_payload_TDATA,
  input  logic [7:0]    usr_rx_payload_TKEEP,
  input  logic          usr_rx_payload_TUSER,
  input  logic          usr_rx_payload_TLAST,
  input  logic          usr_rx_payload_TVALID,
  output logic          usr_rx_payload_TREADY,
  output logic [15:0]   conn_setup_req_V_TDATA,
  output logic          conn_setup_req_V_TVALID,
  input  logic          conn_setup_req_V_TREADY,
  output logic [111:0]  usr_tx_hdr_V_TDATA,
  output logic          usr_tx_hdr_V_TVALID,
  input  logic          usr_tx_hdr_V_TREADY,
  output logic [63:0]   usr_tx_payload_TDATA,
  output logic [7:0]    usr_tx_payload_TKEEP,
  output logic          usr_tx_payload_TUSER,
  output logic          usr_tx_payload_TLAST,
  output logic          usr_tx_payload_TVALID,
  input  logic          usr_tx_payload_TREADY
);

  localparam int TW = 16 - SLOT_W;

  state_t            state;
  udp_hdr_t          hdr_q;
  logic [63:0]       beat0_q;
  logic [SLOT_W-1:0] slot_q;
  logic [SLOT_W-1:0] slot_now;
  logic              rx_hs;
  logic              is_open;
  logic              is_close;
  logic              rx_unused;

  assign rx_hs = usr_rx_payload_TVALID && usr_rx_payload_TREADY;
  assign is_open = beat0_q[39:32] == OPC_OPEN;
`ifdef CONN_CLOSE_EN
  assign is_close = beat0_q[39:32] == OPC_CLOSE;
`else
  assign is_close = 1'b0;
`endif
  // Slot may arrive on the very beat that ends the packet
  assign slot_now = (state == S_RB1) ?
    usr_rx_payload_TDATA[SLOT_W-1:0] : slot_q;

  assign rx_unused = ^{usr_rx_payload_TKEEP, usr_rx_payload_TUSER,
                       hdr_q.length, hdr_q.dst_port};
  assign usr_tx_payload_TUSER = 1'b0;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state                   <= S_IDLE;
      hdr_q                   <= '0;
      beat0_q                 <= '0;
      slot_q                  <= '0;
      usr_rx_hdr_V_TREADY     <= 1'b0;
      usr_rx_payload_TREADY   <= 1'b0;
      conn_setup_req_V_TDATA  <= '0;
      conn_setup_req_V_TVALID <= 1'b0;
      usr_tx_hdr_V_TDATA      <= '0;
      usr_tx_hdr_V_TVALID     <= 1'b0;
      usr_tx_payload_TDATA    <= '0;
      usr_tx_payload_TKEEP    <= '0;
      usr_tx_payload_TLAST    <= 1'b0;
      usr_tx_payload_TVALID   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          usr_rx_hdr_V_TREADY <= 1'b1;
          state               <= S_RHDR;
        end
        S_RHDR: if (usr_rx_hdr_V_TVALID) begin
          hdr_q                 <= usr_rx_hdr_V_TDATA;
          usr_rx_hdr_V_TREADY   <= 1'b0;
          usr_rx_payload_TREADY <= 1'b1;
          state                 <= S_RB0;
        end
        S_RB0: if (rx_hs) begin
          beat0_q <= usr_rx_payload_TDATA;
          if (usr_rx_payload_TLAST) begin
            usr_rx_payload_TREADY <= 1'b0;
            state                 <= S_IDLE;
          end else begin
            state <= S_RB1;
          end
        end
        S_RB1, S_DRAIN: if (rx_hs) begin
          if (state == S_RB1)
            slot_q <= usr_rx_payload_TDATA[SLOT_W-1:0];
          if (usr_rx_payload_TLAST) begin
            usr_rx_payload_TREADY <= 1'b0;
            if (is_open || is_close) begin
              conn_setup_req_V_TVALID <= 1'b1;
              conn_setup_req_V_TDATA  <= {
                is_close ? TW'(SETC_CLOSE) : TW'(SETC_OPEN), slot_now};
              state <= S_SETC;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            state <= S_DRAIN;
          end
        end
        S_SETC: if (conn_setup_req_V_TREADY) begin
          conn_setup_req_V_TVALID <= 1'b0;
          usr_tx_hdr_V_TVALID     <= 1'b1;
          usr_tx_hdr_V_TDATA      <= {16'd16, hdr_q.src_port,
                                      16'(slot_q), hdr_q.src_ip,
                                      hdr_q.dst_ip};
          state <= S_THDR;
        end
        S_THDR: if (usr_tx_hdr_V_TREADY) begin
          usr_tx_hdr_V_TVALID   <= 1'b0;
          usr_tx_payload_TVALID <= 1'b1;
          usr_tx_payload_TDATA  <= beat0_q;
          usr_tx_payload_TKEEP  <= 8'hFF;
          usr_tx_payload_TLAST  <= 1'b0;
          state                 <= S_TB0;
        end
        S_TB0: if (usr_tx_payload_TREADY) begin
          usr_tx_payload_TDATA <= 64'(slot_q);
          usr_tx_payload_TLAST <= 1'b1;
          state                <= S_TB1;
        end
        S_TB1: if (usr_tx_payload_TREADY) begin
          usr_tx_payload_TVALID <= 1'b0;
          usr_tx_payload_TDATA  <= '0;
          usr_tx_payload_TKEEP  <= '0;
          usr_tx_payload_TLAST  <= 1'b0;
          state                 <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conn_setup_responder.sv
// Directed bench for conn_setup_responder: vector table of request packets
// plus backpressure and mid-reply reset sequences.
module tb_conn_setup_responder;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [111:0] rx_hdr_data = '0;
  logic         rx_hdr_valid = 1'b0;
  logic         rx_hdr_ready;
  logic [63:0]  rx_pay_data = '0;
  logic [7:0]   rx_pay_keep = 8'hFF;
  logic         rx_pay_user = 1'b0;
  logic         rx_pay_last = 1'b0;
  logic         rx_pay_valid = 1'b0;
  logic         rx_pay_ready;
  logic [15:0]  setc_data;
  logic         setc_valid;
  logic         setc_ready = 1'b0;
  logic [111:0] txh_data;
  logic         txh_valid;
  logic         txh_ready = 1'b0;
  logic [63:0]  txp_data;
  logic [7:0]   txp_keep;
  logic         txp_user;
  logic         txp_last;
  logic         txp_valid;
  logic         txp_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conn_setup_responder dut (
    .ap_clk                  (clk),
    .ap_rst_n                (rst_n),
    .usr_rx_hdr_V_TDATA      (rx_hdr_data),
    .usr_rx_hdr_V_TVALID     (rx_hdr_valid),
    .usr_rx_hdr_V_TREADY     (rx_hdr_ready),
    .usr_rx_payload_TDATA    (rx_pay_data),
    .usr_rx_payload_TKEEP    (rx_pay_keep),
    .usr_rx_payload_TUSER    (rx_pay_user),
    .usr_rx_payload_TLAST    (rx_pay_last),
    .usr_rx_payload_TVALID   (rx_pay_valid),
    .usr_rx_payload_TREADY   (rx_pay_ready),
    .conn_setup_req_V_TDATA  (setc_data),
    .conn_setup_req_V_TVALID (setc_valid),
    .conn_setup_req_V_TREADY (setc_ready),
    .usr_tx_hdr_V_TDATA      (txh_data),
    .usr_tx_hdr_V_TVALID     (txh_valid),
    .usr_tx_hdr_V_TREADY     (txh_ready),
    .usr_tx_payload_TDATA    (txp_data),
    .usr_tx_payload_TKEEP    (txp_keep),
    .usr_tx_payload_TUSER    (txp_user),
    .usr_tx_payload_TLAST    (txp_last),
    .usr_tx_payload_TVALID   (txp_valid),
    .usr_tx_payload_TREADY   (txp_ready)
  );

  typedef struct {
    logic [111:0] hdr;
    logic [63:0]  b0;
    logic [63:0]  b1;
    int           extra;
    logic         b0_last;
    logic         user;
    logic         cmd;
    logic [15:0]  setc;
    logic [111:0] rhdr;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic send_hdr(input logic [111:0] h);
    int n = 0;
    rx_hdr_valid = 1'b1;
    rx_hdr_data  = h;
    while (!rx_hdr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("hdr_accept", n < 50, 1'b1);
    @(negedge clk);
    rx_hdr_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic l,
                           input logic u);
    int n = 0;
    rx_pay_valid = 1'b1;
    rx_pay_data  = d;
    rx_pay_last  = l;
    rx_pay_user  = u;
    while (!rx_pay_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("beat_accept", n < 50, 1'b1);
    @(negedge clk);
    rx_pay_valid = 1'b0;
    rx_pay_last  = 1'b0;
  endtask

  task automatic send_pkt(input vec_t v);
    send_hdr(v.hdr);
    send_beat(v.b0, v.b0_last, v.user);
    if (!v.b0_last) begin
      send_beat(v.b1, v.extra == 0, v.user);
      for (int i = 0; i < v.extra; i++)
        send_beat(64'hDEAD_BEEF_0000_0000 | 64'(i), i == v.extra - 1,
                  v.user);
    end
  endtask

  task automatic take_setc(input logic [15:0] exp, input int hold);
    int n = 0;
    logic bad = 1'b0;
    while (!setc_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("setc_valid_timeout", n < 50, 1'b1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!setc_valid || setc_data !== exp || rx_hdr_ready || rx_pay_ready)
        bad = 1'b1;
    end
    if (hold > 0) chk("setc_hold_stable", bad, 1'b0);
    chk("setc_data", setc_data, exp);
    setc_ready = 1'b1;
    @(negedge clk);
    setc_ready = 1'b0;
    chk("setc_drop", setc_valid, 1'b0);
  endtask

  task automatic take_txh(input logic [111:0] exp, input int hold);
    int n = 0;
    logic bad = 1'b0;
    while (!txh_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("txh_valid_timeout", n < 50, 1'b1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!txh_valid || txh_data !== exp || rx_hdr_ready || rx_pay_ready)
        bad = 1'b1;
    end
    if (hold > 0) chk("txh_hold_stable", bad, 1'b0);
    chk("txh_data", txh_data, exp);
    txh_ready = 1'b1;
    @(negedge clk);
    txh_ready = 1'b0;
  endtask

  task automatic take_txp(input logic [63:0] exp, input logic last,
                          input int hold);
    int n = 0;
    logic bad = 1'b0;
    while (!txp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("txp_valid_timeout", n < 50, 1'b1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!txp_valid || txp_data !== exp) bad = 1'b1;
    end
    if (hold > 0) chk("txp_hold_stable", bad, 1'b0);
    chk("txp_data", txp_data, exp);
    chk("txp_keep_user_last", {txp_keep, txp_user, txp_last},
        {8'hFF, 1'b0, last});
    txp_ready = 1'b1;
    @(negedge clk);
    txp_ready = 1'b0;
  endtask

  task automatic quiet(input string nm);
    logic any = 1'b0;
    repeat (15) begin
      @(negedge clk);
      any = any | setc_valid | txh_valid | txp_valid;
    end
    chk(nm, any, 1'b0);
  endtask

  task automatic run_vec(input vec_t v, input int hold);
    send_pkt(v);
    if (v.cmd) begin
      chk("setc_latency", setc_valid, 1'b1);
      take_setc(v.setc, hold);
      take_txh(v.rhdr, hold);
      take_txp(v.b0, 1'b0, hold);
      take_txp({54'd0, v.b1[9:0]}, 1'b1, 0);
      chk("txp_idle_after", txp_valid, 1'b0);
    end else begin
      quiet("no_output");
    end
  endtask

  initial begin
    // 0: OPEN 192.168.1.2:20 -> 192.168.1.128:0, slot 10
    vt[0] = '{hdr: {16'd16, 16'd0, 16'd20, 32'hC0A8_0180, 32'hC0A8_0102},
              b0: 64'h0000_0007_0000_0000, b1: 64'd10, extra: 0,
              b0_last: 1'b0, user: 1'b0, cmd: 1'b1, setc: 16'h040A,
              rhdr: {16'd16, 16'd20, 16'd10, 32'hC0A8_0102,
                     32'hC0A8_0180}};
    // 1: DATA to port 10
    vt[1] = '{hdr: {16'd16, 16'd10, 16'd20, 32'hC0A8_0180, 32'hC0A8_0102},
              b0: 64'h0F0F_0F0F_0F0F_0F0F, b1: 64'h0101_0101_0101_0101,
              extra: 0, b0_last: 1'b0, user: 1'b0, cmd: 1'b0, setc: '0,
              rhdr: '0};
    // 2: CLOSE from port 0, slot 10
    vt[2] = '{hdr: {16'd16, 16'd0, 16'd0, 32'hC0A8_0180, 32'hC0A8_0102},
              b0: 64'h0000_0008_0000_0000, b1: 64'd10, extra: 0,
              b0_last: 1'b0, user: 1'b0,
`ifdef CONN_CLOSE_EN
              cmd: 1'b1,
`else
              cmd: 1'b0,
`endif
              setc: 16'h080A,
              rhdr: {16'd16, 16'd0, 16'd10, 32'hC0A8_0102,
                     32'hC0A8_0180}};
    // 3: 4-beat OPEN, max slot, TUSER set, noisy beat0
    vt[3] = '{hdr: {16'd32, 16'd7, 16'h04D2, 32'h0A00_0002, 32'h0A00_0001},
              b0: 64'hA1B2_C307_D4E5_F6A7, b1: 64'h1234_5678_9ABC_D3FF,
              extra: 2, b0_last: 1'b0, user: 1'b1, cmd: 1'b1,
              setc: 16'h07FF,
              rhdr: {16'd16, 16'h04D2, 16'h03FF, 32'h0A00_0001,
                     32'h0A00_0002}};
    // 4: single-beat OPEN opcode -> dropped
    vt[4] = '{hdr: {16'd8, 16'd0, 16'd20, 32'hC0A8_0180, 32'hC0A8_0102},
              b0: 64'h0000_0007_0000_0000, b1: 64'd0, extra: 0,
              b0_last: 1'b1, user: 1'b0, cmd: 1'b0, setc: '0, rhdr: '0};
    // 5: unknown opcode 9 -> DATA
    vt[5] = '{hdr: {16'd16, 16'd0, 16'd20, 32'hC0A8_0180, 32'hC0A8_0102},
              b0: 64'h0000_0009_0000_0000, b1: 64'd5, extra: 0,
              b0_last: 1'b0, user: 1'b0, cmd: 1'b0, setc: '0, rhdr: '0};

    repeat (3) @(negedge clk);
    chk("reset_valids", {setc_valid, txh_valid, txp_valid}, 3'b000);
    chk("reset_readies", {rx_hdr_ready, rx_pay_ready}, 2'b00);
    chk("reset_tx_data", {txp_data, txp_keep, txp_user, txp_last}, 74'd0);
    rst_n = 1'b1;

    // payload before header is held off
    rx_pay_valid = 1'b1;
    rx_pay_data  = 64'h0000_0007_0000_0000;
    begin
      logic seen = 1'b0;
      repeat (4) begin
        @(negedge clk);
        seen = seen | rx_pay_ready;
      end
      chk("payload_before_hdr", seen, 1'b0);
    end
    rx_pay_valid = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vt[i], 0);

    for (int i = 0; i < 10; i++) run_vec(vt[1], 0);

    // backpressure on every reply channel
    run_vec(vt[0], 20);
    run_vec(vt[3], 3);

    // reset while the first reply beat is pending
    send_pkt(vt[0]);
    take_setc(vt[0].setc, 0);
    take_txh(vt[0].rhdr, 0);
    begin
      int n = 0;
      while (!txp_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("tb0_reached", n < 50, 1'b1);
    end
    rst_n = 1'b0;
    #1;
    chk("async_reset_valids", {setc_valid, txh_valid, txp_valid}, 3'b000);
    chk("async_reset_readies", {rx_hdr_ready, rx_pay_ready}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vt[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=done");
    $fatal(1, "timeout");
  end

endmodule
